// File: rtl/cmd_sequencer.sv
// SD host CMD-line command sequencer: frames a command with CRC7, hands it to the
// CMD physical control, checks the response, and retries on timeout or CRC failure.
module cmd_sequencer #(
  parameter int RETRY_MAX   = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  output logic         cmd_busy,
  output logic         cmd_done,
  output logic [2:0]   cmd_error,
  output logic [135:0] response_out,
  output logic         phy_strobe,
  output logic [47:0]  phy_frame,
  output logic         phy_idle,
  output logic         phy_no_response,
  input  logic         phy_ack,
  input  logic         phy_resp_strobe,
  input  logic [135:0] phy_response,
  input  logic         phy_timeout,
  output logic         phy_resp_ack
);

  localparam int WCW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WCW-1:0] ACK_LAST  = WCW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]     RETRY_LIM = 3'(RETRY_MAX);

  typedef enum logic [2:0] {IDLE, CRC, SEND, WAIT_RESP, CHECK, DONE} state_t;

  state_t         state;
  logic [5:0]     idx_reg;
  logic [1:0]     rtype_reg;
  logic [39:0]    shift_reg;
  logic [6:0]     crc_reg;
  logic [5:0]     bit_cnt;
  logic [2:0]     attempt;
  logic [WCW-1:0] wait_cnt;

  logic        fb;
  logic [6:0]  crc_next;
  logic [39:0] rot;
  logic        last_bit;
  logic        retry_ok;
  logic        crc_err;
  logic        idx_err;

  // The serializer rotates rather than shifts, so after 40 steps the header is
  // back in place and can be copied straight into the frame.
  always_comb begin
    fb       = shift_reg[39] ^ crc_reg[6];
    crc_next = {crc_reg[5:3], crc_reg[2] ^ fb, crc_reg[1:0], fb};
    rot      = {shift_reg[38:0], shift_reg[39]};
    last_bit = (bit_cnt == 6'd39);
    retry_ok = (attempt < RETRY_LIM);
    crc_err  = (crc_next != response_out[7:1]) || !response_out[0];
    idx_err  = (response_out[45:40] != idx_reg);
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx_reg         <= '0;
      rtype_reg       <= '0;
      shift_reg       <= '0;
      crc_reg         <= '0;
      bit_cnt         <= '0;
      attempt         <= '0;
      wait_cnt        <= '0;
      cmd_busy        <= 1'b0;
      cmd_done        <= 1'b0;
      cmd_error       <= '0;
      response_out    <= '0;
      phy_strobe      <= 1'b0;
      phy_frame       <= '0;
      phy_idle        <= 1'b1;
      phy_no_response <= 1'b0;
      phy_resp_ack    <= 1'b0;
    end else begin
      cmd_done     <= 1'b0;
      phy_resp_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            idx_reg         <= cmd_index;
            rtype_reg       <= resp_type;
            shift_reg       <= {2'b01, cmd_index, cmd_argument};
            crc_reg         <= '0;
            bit_cnt         <= '0;
            attempt         <= '0;
            cmd_error       <= '0;
            response_out    <= '0;
            cmd_busy        <= 1'b1;
            phy_idle        <= 1'b0;
            phy_no_response <= (resp_type == 2'b00);
            state           <= CRC;
          end
        end
        CRC: begin
          crc_reg   <= crc_next;
          shift_reg <= rot;
          bit_cnt   <= bit_cnt + 6'd1;
          if (last_bit) begin
            phy_frame  <= {rot, crc_next, 1'b1};
            phy_strobe <= 1'b1;
            wait_cnt   <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          // A low strobe here is the one-cycle gap after an ack timeout retry.
          if (!phy_strobe) begin
            phy_strobe <= 1'b1;
          end else if (phy_ack) begin
            phy_strobe <= 1'b0;
            if (rtype_reg == 2'b00) begin
              cmd_done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT_RESP;
            end
          end else if (wait_cnt == ACK_LAST) begin
            phy_strobe <= 1'b0;
            wait_cnt   <= '0;
            if (retry_ok) begin
              attempt <= attempt + 3'd1;
            end else begin
              cmd_error <= 3'b001;
              cmd_done  <= 1'b1;
              state     <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        WAIT_RESP: begin
          if (phy_resp_strobe) begin
            response_out <= phy_response;
            phy_resp_ack <= 1'b1;
            if (rtype_reg == 2'b01) begin
              shift_reg <= phy_response[47:8];
              crc_reg   <= '0;
              bit_cnt   <= '0;
              state     <= CHECK;
            end else begin
              cmd_done <= 1'b1;
              state    <= DONE;
            end
          end else if (phy_timeout) begin
            if (retry_ok) begin
              attempt    <= attempt + 3'd1;
              phy_strobe <= 1'b1;
              wait_cnt   <= '0;
              state      <= SEND;
            end else begin
              cmd_error <= 3'b001;
              cmd_done  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        CHECK: begin
          crc_reg   <= crc_next;
          shift_reg <= rot;
          bit_cnt   <= bit_cnt + 6'd1;
          if (last_bit) begin
            // A CRC failure is retried even when the index is also wrong.
            if (crc_err && retry_ok) begin
              attempt    <= attempt + 3'd1;
              phy_strobe <= 1'b1;
              wait_cnt   <= '0;
              state      <= SEND;
            end else begin
              cmd_error <= {idx_err, crc_err, 1'b0};
              cmd_done  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          cmd_busy        <= 1'b0;
          phy_idle        <= 1'b1;
          phy_no_response <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: a table of directed commands, a few hand-built corner
// sequences, then random commands checked against a CRC-by-division reference model.
module tb_cmd_sequencer;
  localparam int RMAX = 2;
  localparam int ATO  = 16;
  localparam int K_GOOD = 0, K_BADCRC = 1, K_BADEND = 2, K_PTO = 3, K_ACKTO = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_argument = '0;
  logic [1:0]   resp_type = '0;
  logic         cmd_busy, cmd_done;
  logic [2:0]   cmd_error;
  logic [135:0] response_out;
  logic         phy_strobe, phy_idle, phy_no_response, phy_resp_ack;
  logic [47:0]  phy_frame;
  logic         phy_ack = 1'b0;
  logic         phy_resp_strobe = 1'b0;
  logic [135:0] phy_response = '0;
  logic         phy_timeout = 1'b0;

  always #5 clk = ~clk;

  cmd_sequencer #(.RETRY_MAX(RMAX), .ACK_TIMEOUT(ATO)) dut (
    .sd_clock(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_argument(cmd_argument), .resp_type(resp_type), .cmd_busy(cmd_busy),
    .cmd_done(cmd_done), .cmd_error(cmd_error), .response_out(response_out),
    .phy_strobe(phy_strobe), .phy_frame(phy_frame), .phy_idle(phy_idle),
    .phy_no_response(phy_no_response), .phy_ack(phy_ack),
    .phy_resp_strobe(phy_resp_strobe), .phy_response(phy_response),
    .phy_timeout(phy_timeout), .phy_resp_ack(phy_resp_ack)
  );

  int checks = 0;
  int errors = 0;

  logic strobe_q = 1'b0;
  int   strobe_rises = 0;
  always @(negedge clk) begin
    strobe_q <= phy_strobe;
    if (phy_strobe && !strobe_q) strobe_rises <= strobe_rises + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       tag;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rt;
    logic [23:0] beh;
    bit          bidx;
    bit          poke;
    logic [47:0] ovr;
    logic [47:0] frame;
    logic [2:0]  err;
    int          n;
  } vec_t;

  vec_t tbl[$];

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [23:0] mk(input int a, input int b, input int c);
    return {15'd0, 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mkv(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                               input logic [1:0] rt, input logic [23:0] beh, input bit bidx,
                               input bit poke, input logic [47:0] ovr, input logic [47:0] frame,
                               input logic [2:0] err, input int n);
    vec_t v;
    v.tag = tag; v.idx = idx; v.arg = arg; v.rt = rt; v.beh = beh; v.bidx = bidx;
    v.poke = poke; v.ovr = ovr; v.frame = frame; v.err = err; v.n = n;
    return v;
  endfunction

  // Outcome of a command given what the phy does on each attempt.
  function automatic void predict(input logic [1:0] rt, input logic [23:0] beh, input bit bidx,
                                  output int n, output logic [2:0] err);
    bit to, ce;
    int kind;
    n = RMAX + 1;
    err = 3'b000;
    for (int k = 0; k <= RMAX; k++) begin
      kind = int'(beh[3*k +: 3]);
      to = (kind == K_ACKTO) || (rt != 2'b00 && kind == K_PTO);
      ce = !to && rt == 2'b01 && (kind == K_BADCRC || kind == K_BADEND);
      if (!to && !ce) begin
        n = k + 1;
        err = (rt == 2'b01 && bidx) ? 3'b100 : 3'b000;
        return;
      end
      if (k == RMAX) begin
        n = k + 1;
        err = to ? 3'b001 : {bidx, 2'b10};
        return;
      end
    end
  endfunction

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_event(input int first, input int limit, output int cyc, output bit dn);
    cyc = first;
    dn = 1'b0;
    while (!(cmd_done || phy_strobe)) begin
      if (cyc >= limit) begin
        cyc = -1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    dn = cmd_done;
  endtask

  task automatic recover();
    phy_ack = 1'b0; phy_resp_strobe = 1'b0; phy_timeout = 1'b0; cmd_start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input logic [23:0] beh, input bit bidx,
                         input bit poke, input logic [47:0] ovr, input logic [47:0] xframe,
                         input logic [2:0] xerr, input int xn);
    int cyc, base, kind, h, xcyc;
    bit dn, ok;
    logic [135:0] resp, last_resp;
    logic [5:0] ridx;
    logic [6:0] rcrc;
    cmd_index = idx; cmd_argument = arg; resp_type = rt; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    base = strobe_rises;
    last_resp = '0;
    check({tag, " busy"}, cmd_busy, 1'b1);
    check({tag, " idle"}, phy_idle, 1'b0);
    check({tag, " no_resp"}, phy_no_response, rt == 2'b00);
    check({tag, " err_clr"}, cmd_error, 3'b000);
    check({tag, " resp_clr"}, response_out, '0);
    if (poke) begin
      cmd_index = ~idx; cmd_argument = ~arg; resp_type = ~rt; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      wait_event(2, 100, cyc, dn);
    end else begin
      wait_event(1, 100, cyc, dn);
    end
    check({tag, " strobe_lat"}, cyc, 41);
    check({tag, " started"}, dn, 1'b0);
    check({tag, " frame"}, phy_frame, xframe);
    ok = (cyc > 0) && !dn;
    for (int k = 0; ok && k < xn; k++) begin
      kind = int'(beh[3*k +: 3]);
      if (kind == K_ACKTO) begin
        h = 1;
        while (phy_strobe && h < ATO + 10) begin
          @(negedge clk);
          h++;
        end
        check({tag, " ack_to_len"}, h, ATO + 1);
        xcyc = (k == xn - 1) ? 1 : 2;
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        phy_ack = 1'b1;
        @(negedge clk);
        phy_ack = 1'b0;
        check({tag, " strobe_drop"}, phy_strobe, 1'b0);
        xcyc = 1;
        if (rt != 2'b00) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          if (kind == K_PTO) begin
            phy_timeout = 1'b1;
            @(negedge clk);
            phy_timeout = 1'b0;
          end else begin
            ridx = bidx ? (idx ^ 6'h19) : idx;
            rcrc = crc7({2'b00, ridx, arg});
            if (kind == K_BADCRC) rcrc = rcrc ^ 7'h01;
            resp = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            resp[47:0] = {2'b00, ridx, arg, rcrc, kind != K_BADEND};
            if (ovr != '0) resp[47:0] = ovr;
            phy_response = resp;
            phy_resp_strobe = 1'b1;
            @(negedge clk);
            phy_resp_strobe = 1'b0;
            last_resp = resp;
            check({tag, " resp_ack"}, phy_resp_ack, 1'b1);
            if (rt == 2'b01) xcyc = 41;
          end
        end
      end
      wait_event(1, 60, cyc, dn);
      check({tag, " evt_lat"}, cyc, xcyc);
      check({tag, " evt_done"}, dn, k == xn - 1);
      if (cyc < 0 || dn != (k == xn - 1)) ok = 1'b0;
    end
    if (ok) begin
      check({tag, " cmd_error"}, cmd_error, xerr);
      check({tag, " response"}, response_out, last_resp);
      check({tag, " busy_at_done"}, cmd_busy, 1'b1);
      check({tag, " strobes"}, strobe_rises - base, xn);
      @(negedge clk);
      check({tag, " done_pulse"}, cmd_done, 1'b0);
      check({tag, " busy_end"}, cmd_busy, 1'b0);
      check({tag, " idle_end"}, phy_idle, 1'b1);
      check({tag, " no_resp_end"}, phy_no_response, 1'b0);
    end else begin
      recover();
    end
    $display("txn %s idx=0x%0h arg=0x%08h type=%0d attempts=%0d err=%b", tag, idx, arg, rt, xn, cmd_error);
  endtask

  initial begin
    int cyc, n, r;
    bit dn, bidx;
    logic [2:0] err;
    logic [5:0] idx;
    logic [31:0] arg;
    logic [1:0] rt;
    logic [23:0] beh;

    repeat (2) @(negedge clk);
    check("rst busy", cmd_busy, 1'b0);
    check("rst done", cmd_done, 1'b0);
    check("rst error", cmd_error, 3'b000);
    check("rst response", response_out, '0);
    check("rst strobe", phy_strobe, 1'b0);
    check("rst frame", phy_frame, '0);
    check("rst idle", phy_idle, 1'b1);
    check("rst no_resp", phy_no_response, 1'b0);
    check("rst resp_ack", phy_resp_ack, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    tbl.push_back(mkv("cmd0", 6'd0, 32'h0, 2'd0, mk(K_GOOD, K_GOOD, K_GOOD), 0, 0, 48'h0,
                      48'h40_0000_0000_95, 3'b000, 1));
    tbl.push_back(mkv("cmd8", 6'd8, 32'h1AA, 2'd1, mk(K_GOOD, K_GOOD, K_GOOD), 0, 0,
                      48'h08_0000_01AA_13, 48'h48_0000_01AA_87, 3'b000, 1));
    tbl.push_back(mkv("cmd17_retry", 6'd17, 32'h200, 2'd1, mk(K_BADCRC, K_GOOD, K_GOOD), 0, 0,
                      48'h0, mkframe(6'd17, 32'h200), 3'b000, 2));
    tbl.push_back(mkv("timeout_all", 6'd17, 32'h1000, 2'd1, mk(K_PTO, K_PTO, K_PTO), 0, 0,
                      48'h0, mkframe(6'd17, 32'h1000), 3'b001, 3));
    tbl.push_back(mkv("bad_index", 6'd8, 32'h1AA, 2'd1, mk(K_GOOD, K_GOOD, K_GOOD), 1, 1,
                      48'h0, 48'h48_0000_01AA_87, 3'b100, 1));
    tbl.push_back(mkv("r2_long", 6'd2, 32'h0, 2'd2, mk(K_GOOD, K_GOOD, K_GOOD), 0, 0,
                      48'h0, mkframe(6'd2, 32'h0), 3'b000, 1));
    tbl.push_back(mkv("r3_nocheck", 6'd41, 32'h00FF8000, 2'd3, mk(K_BADCRC, K_GOOD, K_GOOD), 0, 0,
                      48'h0, mkframe(6'd41, 32'h00FF8000), 3'b000, 1));
    tbl.push_back(mkv("bad_end", 6'd13, 32'h10000, 2'd1, mk(K_BADEND, K_BADEND, K_BADEND), 0, 0,
                      48'h0, mkframe(6'd13, 32'h10000), 3'b010, 3));
    tbl.push_back(mkv("ack_to_once", 6'd0, 32'h0, 2'd0, mk(K_ACKTO, K_GOOD, K_GOOD), 0, 0,
                      48'h0, 48'h40_0000_0000_95, 3'b000, 2));
    tbl.push_back(mkv("ack_to_all", 6'd55, 32'hDEADBEEF, 2'd1, mk(K_ACKTO, K_ACKTO, K_ACKTO), 0, 0,
                      48'h0, mkframe(6'd55, 32'hDEADBEEF), 3'b001, 3));
    tbl.push_back(mkv("crc_idx_all", 6'd9, 32'h12345678, 2'd1, mk(K_BADCRC, K_BADCRC, K_BADCRC), 1, 0,
                      48'h0, mkframe(6'd9, 32'h12345678), 3'b110, 3));
    tbl.push_back(mkv("mixed", 6'd6, 32'h03B70100, 2'd1, mk(K_PTO, K_BADCRC, K_GOOD), 0, 0,
                      48'h0, mkframe(6'd6, 32'h03B70100), 3'b000, 3));
    tbl.push_back(mkv("r3_pto", 6'd41, 32'h40300000, 2'd3, mk(K_PTO, K_GOOD, K_GOOD), 0, 0,
                      48'h0, mkframe(6'd41, 32'h40300000), 3'b000, 2));

    foreach (tbl[i])
      run_txn(tbl[i].tag, tbl[i].idx, tbl[i].arg, tbl[i].rt, tbl[i].beh, tbl[i].bidx,
              tbl[i].poke, tbl[i].ovr, tbl[i].frame, tbl[i].err, tbl[i].n);

    // Reset while the frame is being offered to the phy.
    cmd_index = 6'd24; cmd_argument = 32'h0000_0400; resp_type = 2'd1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_event(1, 100, cyc, dn);
    check("rst_mid strobe_up", phy_strobe, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid strobe", phy_strobe, 1'b0);
    check("rst_mid idle", phy_idle, 1'b1);
    check("rst_mid busy", cmd_busy, 1'b0);
    check("rst_mid frame", phy_frame, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid no_done", cmd_done, 1'b0);
    end
    run_txn("after_rst", 6'd24, 32'h400, 2'd1, mk(K_GOOD, K_GOOD, K_GOOD), 0, 0, 48'h0,
            mkframe(6'd24, 32'h400), 3'b000, 1);

    for (int t = 0; t < 20; t++) begin
      idx = 6'($urandom);
      arg = $urandom;
      rt  = 2'($urandom);
      beh = '0;
      for (int k = 0; k < 3; k++) begin
        r = int'($urandom_range(0, 9));
        beh[3*k +: 3] = (r < 5) ? 3'(K_GOOD) : (r < 7) ? 3'(K_BADCRC) : (r == 7) ? 3'(K_BADEND) :
                        (r == 8) ? 3'(K_PTO) : 3'(K_ACKTO);
      end
      bidx = ($urandom_range(0, 4) == 0);
      predict(rt, beh, bidx, n, err);
      run_txn($sformatf("rnd%0d", t), idx, arg, rt, beh, bidx, 1'b0, 48'h0, mkframe(idx, arg), err, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command-layer sequencer for the SD host CMD line. It accepts a command request from the host register side and builds the 48-bit CMD frame, including a serially computed CRC7. It hands the frame to the CMD physical-layer control block through a strobe/ack handshake, collects and checks the response, and retries on timeout or CRC failure. It sits between the host register interface and the CMD physical-layer control, and is the only driver of that block's request-side inputs.

## Interface
Parameters:
- RETRY_MAX, 2, number of re-sends after the first attempt on timeout/CRC error (0..7)
- ACK_TIMEOUT, 1024, cycles phy_strobe may wait for phy_ack before a timeout is declared

Ports:
- sd_clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  request pulse; sampled only in IDLE
- cmd_index  in  6  command index; captured on accepted cmd_start
- cmd_argument  in  32  argument; captured on accepted cmd_start
- resp_type  in  2  00 none, 01 48-bit checked, 10 136-bit, 11 48-bit unchecked (R3); captured on start
- cmd_busy  out  1  high from acceptance through DONE
- cmd_done  out  1  one-cycle completion pulse
- cmd_error  out  3  [0] timeout, [1] crc/end-bit error, [2] index mismatch; valid with cmd_done, held until next accepted start
- response_out  out  136  captured phy_response, held until next accepted start
- phy_strobe  out  1  frame request to physical control (its strobe_in)
- phy_frame  out  48  {0,1,index,argument,crc7,1}; stable while phy_strobe high
- phy_idle  out  1  high only in IDLE (its idle_in)
- phy_no_response  out  1  high while busy with resp_type==00
- phy_ack  in  1  physical control accepted frame (its ack_out)
- phy_resp_strobe  in  1  response available (its strobe_out)
- phy_response  in  136  response bits, valid with phy_resp_strobe
- phy_timeout  in  1  physical control command_timeout
- phy_resp_ack  out  1  one-cycle response acknowledge (its ack_in)

## Operation
- States: IDLE, CRC, SEND, WAIT_RESP, CHECK, DONE.
- IDLE: cmd_start=1 captures the inputs, clears cmd_error/response_out, sets the attempt counter to 0, and moves to CRC. A start while not in IDLE is ignored.
- CRC: shifts the 40 bits {0,1,index,argument} MSB first through the CRC7 LFSR (x^7+x^3+1, init 0), one bit per cycle, 40 cycles. It then loads phy_frame and moves to SEND.
- SEND: phy_strobe=1 until phy_ack is sampled high, then phy_strobe=0.
  - resp_type 00 → DONE.
  - Otherwise → WAIT_RESP.
  - If the wait counter reaches ACK_TIMEOUT → timeout handling.
- WAIT_RESP: on phy_resp_strobe, capture response_out, pulse phy_resp_ack, and move on:
  - type 01 → CHECK.
  - types 10/11 → DONE.
  - On phy_timeout → timeout handling.
  - If both are high in the same cycle, phy_resp_strobe wins.
- CHECK (type 01, 40 cycles): CRC7 over response[47:8].
  - crc_err if the result ≠ response[7:1] or response[0]≠1.
  - index_err if response[45:40]≠captured index.
- Retry: on timeout or crc_err, if attempt < RETRY_MAX, increment attempt, clear the flag, and go back to SEND (frame is reused, no CRC recompute). Otherwise set the flag and go to DONE.
- index_err is never retried. If crc_err and index_err occur together, crc_err retry rules apply first.
- DONE: one cycle with cmd_done=1 and cmd_busy=1, then IDLE.

## Timing
- Reset values: cmd_busy 0, cmd_done 0, cmd_error 0, response_out 0, phy_strobe 0, phy_frame 0, phy_idle 1, phy_no_response 0, phy_resp_ack 0.
- Start sampled at edge N:
  - cmd_busy=1 and phy_idle=0 from N+1.
  - CRC occupies N+1..N+40.
  - phy_strobe=1 from N+41.
- phy_ack sampled at edge A: phy_strobe=0 from A+1.
- phy_resp_strobe sampled at edge R: phy_resp_ack=1 during R+1 only.
  - Type 01: CHECK runs R+1..R+40, cmd_done at R+41.
  - Types 10/11: cmd_done at R+1.
- No-response command: cmd_done at A+1.
- Reset asserted mid-operation: all outputs go to their reset values immediately and the state returns to IDLE; no done pulse is issued.
- The ACK_TIMEOUT counter restarts on every SEND entry.

## Test plan
- CMD0, arg 0, type 00 → phy_frame=0x40_0000_0000_95, phy_no_response=1; after phy_ack, cmd_done with cmd_error=000.
- CMD8, arg 0x000001AA, type 01 → phy_frame=0x48_0000_01AA_87; response[47:0]=0x08_0000_01AA_13 → cmd_done at R+41, cmd_error=000.
- CMD17 with a corrupted response CRC on attempt 0 and a correct one on attempt 1 → two phy_strobe assertions, final cmd_error=000.
- phy_timeout on every attempt, RETRY_MAX=2 → exactly 3 phy_strobe assertions, cmd_error=001.
- Response index 0x11 for a CMD8 request → no retry, cmd_error=100. A cmd_start during busy is ignored.
- Reset asserted while phy_strobe=1 → phy_strobe=0, phy_idle=1, and cmd_busy=0 at once; a new start afterwards completes normally.
